mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (loads/stores).
- Serialises each 1/2/4-byte access into per-byte RAM cycles and assembles or sign-extends the read data.
- Sits between the IF stage, the MEM stage and the RAM; drives a stall request to the stall controller.
- MEM requests arrive as a toggle on mem_inquiry, driven by the EX/MEM register; IF requests are level-held.

Parameters:
ADDR_W, 32, RAM byte-address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  level; IF wants a 32-bit fetch; held until if_done or dropped (flush)
if_addr  in  ADDR_W  fetch byte address; stable while if_req=1
if_data  out  32  fetched word; valid only while if_done=1
if_done  out  1  one-cycle completion pulse
mem_inquiry  in  1  toggles once per new MEM-stage access
mem_we  in  1  1=store, 0=load
mem_size  in  2  0=byte, 1=half, 2=word; 3 is illegal
mem_sext  in  1  sign-extend byte/half loads
mem_addr  in  ADDR_W  access byte address
mem_wdata  in  32  store data; low bytes are used for byte/half
mem_rdata  out  32  load result; valid only while mem_done=1
mem_done  out  1  one-cycle completion pulse
mem_busy  out  1  stall request to the stall controller
ram_a  out  ADDR_W  RAM byte address (registered)
ram_dout  out  8  RAM write byte (registered)
ram_wr  out  1  RAM write enable (registered)
ram_din  in  8  RAM read byte; returns data for the address presented one edge earlier

Behaviour:
Clock and reset:
- One clock, clk. Synchronous active-high reset rst.
- Reset values: state=IDLE, ram_a=0, ram_dout=0, ram_wr=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0, seen=0, byte counter=0.
- Reset mid-access aborts the access immediately: no done pulse, ram_wr=0.

Pending detection:
- Internal register seen; a MEM access is pending when mem_inquiry != seen.
- seen<=mem_inquiry at the accepting edge.
- mem_busy is combinational: (mem_inquiry != seen) OR state in {MEM_RD, MEM_WR}. It is forced 0 in the cycle mem_done=1.

States: IDLE, IF_RD, MEM_RD, MEM_WR.

IDLE:
- MEM pending has priority over if_req (older instruction).
- On accept, capture addr/size/we/sext/wdata.
- Go to MEM_WR if we=1, else MEM_RD. Otherwise go to IF_RD if if_req=1.

Byte count n:
- n=1/2/4 for size 0/1/2; IF always uses n=4.
- Acceptance edge is E0. At edge Ek (k<n), ram_a<=addr+k; ram_a wraps modulo 2^ADDR_W.

Reads:
- ram_wr=0 throughout.
- Byte k is captured from ram_din at edge E(k+1), little-endian (byte0 is LSB).

Writes:
- At Ek, ram_wr<=1 and ram_dout<=wdata[8k+7:8k].

Completion at edge En, for both reads and writes:
- ram_wr<=0; done<=1 for exactly one cycle; result register valid; state<=IDLE.
- Latency from acceptance to the done pulse is n cycles.
- Unused upper result bits: zero-filled, or sign-filled when mem_sext=1.
- The next request may be accepted at the edge where done falls; there are no idle bubbles beyond that.

IF flush:
- if_req=0 observed in IF_RD aborts at the next edge: state=IDLE, no if_done.

Simultaneous events:
- A mem_inquiry toggle during IF_RD stays pending and is served immediately after the fetch completes or aborts.
- mem_busy rises in the same cycle as the toggle.
- A second toggle before acceptance is illegal; the MEM stage is stalled by mem_busy, so it cannot occur.
- mem_size=3 is treated as word.

Test Plan:
1. Reset then idle: all outputs 0, mem_busy=0; hold if_req=0 for 10 cycles -> ram_wr stays 0.
2. IF fetch from 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 on consecutive edges; if_done pulses 4 cycles after acceptance; if_data=0x00100513.
3. Toggle mem_inquiry with a word store 0xDEADBEEF to 0x20 -> ram_wr=1 for 4 cycles writing EF,BE,AD,DE to 0x20..0x23; mem_done pulses in the next cycle; mem_busy=1 from the toggle cycle until mem_done.
4. Byte load from 0x7 with RAM byte 0x80, sext=1 -> mem_rdata=0xFFFFFF80; repeat with sext=0 -> 0x00000080. Half load from 0x10 with bytes 0x34,0x12 -> 0x00001234.
5. if_req and an inquiry toggle in the same cycle -> MEM access served first, then the IF fetch starts at the edge mem_done falls. Toggle during IF_RD -> MEM access starts right after if_done.
6. Drop if_req after 2 bytes of a fetch -> no if_done, state back to IDLE. Assert rst during a word store -> ram_wr=0 at the next edge, no mem_done, seen=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// the MEM stage. Each 1/2/4-byte access is split into one RAM cycle per byte,
// with byte 0 as the least significant byte. Read data is assembled and then
// zero- or sign-extended. MEM requests are signalled by a toggle on
// mem_inquiry and take priority over a fetch that arrives in the same cycle.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              mem_inquiry,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic              mem_sext,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              mem_busy,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   input  logic [7:0]        ram_din
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IF_RD  = 2'd1,
      ST_MEM_RD = 2'd2,
      ST_MEM_WR = 2'd3
   } state_e;

   // Number of byte cycles for an access size; size 3 behaves as a word.
   function automatic logic [2:0] size_to_len(input logic [1:0] size);
      logic [2:0] len;
      case (size)
         2'd0:    len = 3'd1;
         2'd1:    len = 3'd2;
         default: len = 3'd4;
      endcase
      return len;
   endfunction

   // Replace one byte lane of a word with a newly read RAM byte.
   function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
      logic [31:0] res;
      res = word;
      case (idx)
         2'd0:    res[7:0]   = b;
         2'd1:    res[15:8]  = b;
         2'd2:    res[23:16] = b;
         2'd3:    res[31:24] = b;
         default: res        = word;
      endcase
      return res;
   endfunction

   // Select one byte lane of the store data.
   function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      return b;
   endfunction

   // Fill the unused upper bits of a byte or half load.
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [1:0]  size,
                                               input logic        sext);
      logic [31:0] res;
      case (size)
         2'd0:    res = sext ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
         2'd1:    res = sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   state_e            state_q,     state_d;
   logic [2:0]        cnt_q,       cnt_d;
   logic [2:0]        len_q,       len_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [31:0]       wdata_q,     wdata_d;
   logic [1:0]        size_q,      size_d;
   logic              sext_q,      sext_d;
   logic [31:0]       rbuf_q,      rbuf_d;
   logic              seen_q,      seen_d;
   logic [ADDR_W-1:0] ram_a_q,     ram_a_d;
   logic [7:0]        ram_dout_q,  ram_dout_d;
   logic              ram_wr_q,    ram_wr_d;
   logic              if_done_q,   if_done_d;
   logic              mem_done_q,  mem_done_d;
   logic [31:0]       if_data_q,   if_data_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;

   logic              pending_s;
   logic [ADDR_W-1:0] byte_addr_s;
   logic [2:0]        prev_cnt_s;
   logic [31:0]       rbuf_next_s;

   assign pending_s   = (mem_inquiry != seen_q);
   assign byte_addr_s = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
   assign prev_cnt_s  = cnt_q - 3'd1;
   assign rbuf_next_s = insert_byte(rbuf_q, prev_cnt_s[1:0], ram_din);

   assign if_data   = if_data_q;
   assign if_done   = if_done_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_done  = mem_done_q;
   assign ram_a     = ram_a_q;
   assign ram_dout  = ram_dout_q;
   assign ram_wr    = ram_wr_q;

   // Stall request: a pending toggle or a MEM access in flight, released in the done cycle.
   assign mem_busy = (pending_s || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR))
                     && !mem_done_q;

   // Next-state and datapath: accept, step one byte per cycle, complete or abort.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      sext_d      = sext_q;
      rbuf_d      = rbuf_q;
      seen_d      = seen_q;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = ram_wr_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (pending_s) begin
               seen_d  = mem_inquiry;
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               size_d  = mem_size;
               sext_d  = mem_sext;
               len_d   = size_to_len(mem_size);
               rbuf_d  = 32'd0;
               ram_a_d = mem_addr;
               cnt_d   = 3'd1;
               if (mem_we) begin
                  state_d    = ST_MEM_WR;
                  ram_wr_d   = 1'b1;
                  ram_dout_d = mem_wdata[7:0];
               end else begin
                  state_d  = ST_MEM_RD;
                  ram_wr_d = 1'b0;
               end
            end else if (if_req) begin
               state_d  = ST_IF_RD;
               addr_d   = if_addr;
               size_d   = 2'd2;
               sext_d   = 1'b0;
               len_d    = 3'd4;
               rbuf_d   = 32'd0;
               ram_a_d  = if_addr;
               cnt_d    = 3'd1;
               ram_wr_d = 1'b0;
            end else begin
               ram_wr_d = 1'b0;
            end
         end

         ST_IF_RD: begin
            if (!if_req) begin
               // Fetch flushed: drop it silently.
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == len_q) begin
               state_d   = ST_IDLE;
               cnt_d     = 3'd0;
               if_done_d = 1'b1;
               if_data_d = rbuf_next_s;
            end else begin
               ram_a_d = byte_addr_s;
               rbuf_d  = rbuf_next_s;
               cnt_d   = cnt_q + 3'd1;
            end
         end

         ST_MEM_RD: begin
            if (cnt_q == len_q) begin
               state_d     = ST_IDLE;
               cnt_d       = 3'd0;
               mem_done_d  = 1'b1;
               mem_rdata_d = extend_load(rbuf_next_s, size_q, sext_q);
            end else begin
               ram_a_d = byte_addr_s;
               rbuf_d  = rbuf_next_s;
               cnt_d   = cnt_q + 3'd1;
            end
         end

         ST_MEM_WR: begin
            if (cnt_q == len_q) begin
               state_d    = ST_IDLE;
               cnt_d      = 3'd0;
               ram_wr_d   = 1'b0;
               mem_done_d = 1'b1;
            end else begin
               ram_a_d    = byte_addr_s;
               ram_dout_d = pick_byte(wdata_q, cnt_q[1:0]);
               ram_wr_d   = 1'b1;
               cnt_d      = cnt_q + 3'd1;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            cnt_d    = 3'd0;
            ram_wr_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset that aborts any access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         len_q       <= 3'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         size_q      <= 2'd0;
         sext_q      <= 1'b0;
         rbuf_q      <= 32'd0;
         seen_q      <= 1'b0;
         ram_a_q     <= '0;
         ram_dout_q  <= 8'd0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         rbuf_q      <= rbuf_d;
         seen_q      <= seen_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

endmodule
